// File: rtl/keccak_pkg.sv
// Purpose : shared Keccak-f[1600] constants for the lane-serial inverse Rho block.
// Latency : n/a (package only).
// Backpressure: n/a. Holds the lane/state widths, per-lane Rho offsets and FSM state enum.
package keccak_pkg;

   localparam int LANE_W    = 64;
   localparam int NUM_LANES = 25;
   localparam int STATE_W   = LANE_W * NUM_LANES;   // 1600

   // Rho rotation offsets, indexed by lane i = 5*y + x.
   localparam logic [5:0] RHO_OFS [NUM_LANES] = '{
      6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
      6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
      6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
      6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
      6'd18, 6'd2,  6'd61, 6'd56, 6'd14
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } rho_state_e;

endpackage

// File: rtl/lane_rotr.sv
// Purpose : 64-bit rotate-right of one Keccak lane by a 6-bit amount.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of din/amt.
// Ports   : din (lane in), amt (rotate amount 0..63), dout (rotated lane).
module lane_rotr
   import keccak_pkg::*;
(
   input  logic [LANE_W-1:0] din,
   input  logic [5:0]        amt,
   output logic [LANE_W-1:0] dout
);

   // Shifting a doubled copy avoids the shift-by-64 corner when amt is 0.
   logic [2*LANE_W-1:0] dbl;

   assign dbl  = {din, din} >> amt;
   assign dout = dbl[LANE_W-1:0];

endmodule

// File: rtl/rho_inv_serial.sv
// Purpose : inverse Keccak Rho, rotating each lane right by its offset, LPC lanes per cycle
//           through shared rotators; optional macro RHO_INV_OVERLAP_EN lets DONE accept the next state.
// Latency : accept edge k -> out_valid after edge k+N (N = 25/LPC); out_data held until out_ready.
// Ports   : clk, rst_n (async active-low), in_valid/in_ready/in_data (1600b state),
//           out_valid/out_ready/out_data (1600b result), busy (RUN or DONE).
// Backpressure: in_ready low in RUN; in DONE low unless RHO_INV_OVERLAP_EN, then in_ready = out_ready.
module rho_inv_serial
   import keccak_pkg::*;
#(
   parameter int LPC = 1   // lanes per cycle; legal values 1, 5, 25
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_data,
   output logic               busy
);

   localparam int N = NUM_LANES / LPC;

   rho_state_e         state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [STATE_W-1:0] shadow_q, shadow_d;
   logic [STATE_W-1:0] out_q, out_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic               accept;
   logic [4:0]         base_lane;
   logic [4:0]         lane_idx [LPC];
   logic [LANE_W-1:0]  rot_in   [LPC];
   logic [LANE_W-1:0]  rot_out  [LPC];
   logic [5:0]         rot_amt  [LPC];

   // in_ready is gated by rst_n so nothing is accepted while reset is held.
`ifdef RHO_INV_OVERLAP_EN
   assign in_ready = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
`else
   assign in_ready = rst_n & (state_q == ST_IDLE);
`endif

   assign accept    = in_valid & in_ready;
   // cnt stays within 0..N-1 so base_lane + j never leaves 0..24.
   assign base_lane = 5'(cnt_q * 5'(LPC));

   for (genvar j = 0; j < LPC; j++) begin : g_lane
      assign lane_idx[j] = base_lane + 5'(j);
      assign rot_in[j]   = shadow_q[LANE_W*lane_idx[j] +: LANE_W];
      assign rot_amt[j]  = RHO_OFS[lane_idx[j]];

      lane_rotr u_rotr (
         .din  (rot_in[j]),
         .amt  (rot_amt[j]),
         .dout (rot_out[j])
      );
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_d    = shadow_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               shadow_d = in_data;
               cnt_d    = 5'd0;
               state_d  = ST_RUN;
               busy_d   = 1'b1;
            end
         end

         ST_RUN: begin
            for (int j = 0; j < LPC; j++) begin
               out_d[LANE_W*lane_idx[j] +: LANE_W] = rot_out[j];
            end
            if (cnt_q == 5'(N - 1)) begin
               cnt_d       = 5'd0;
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               // accept can only be high here when overlap is compiled in.
               if (accept) begin
                  shadow_d = in_data;
                  cnt_d    = 5'd0;
                  state_d  = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            end
         end

         default: begin
            state_d     = ST_IDLE;
            cnt_d       = 5'd0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 5'd0;
         shadow_q    <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_q;
   assign busy      = busy_q;

endmodule
